// File: rtl/ir_nec_transmitter.sv
// NEC infrared transmitter: serialises address/command frames or repeat codes
// into a mark/space envelope and a carrier-modulated LED drive.
module ir_nec_transmitter #(
    parameter int TICK_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int GAP_UNITS    = 72
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic       tx_repeat,
    input  logic [7:0] address,
    input  logic [7:0] command,
    output logic       busy,
    output logic       done,
    output logic       ir_envelope,
    output logic       ir_out
);

    localparam int CYC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CAR_W = $clog2(CARRIER_HALF + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICK_CYCLES - 1);
    localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CARRIER_HALF - 1);
    localparam logic [7:0]       GAP_LAST = 8'(GAP_UNITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    state_t           state;
    logic [CYC_W-1:0] cyc_cnt;
    logic [7:0]       units_left;
    logic [4:0]       bit_idx;
    logic [31:0]      shift_word;
    logic             is_repeat;
    logic [CAR_W-1:0] car_cnt;

    // units_left counts units still to go after the current one
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cyc_cnt     <= '0;
            units_left  <= '0;
            bit_idx     <= '0;
            shift_word  <= '0;
            is_repeat   <= 1'b0;
            car_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ir_envelope <= 1'b0;
            ir_out      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the later, more specific
            // assignments below override these per-cycle defaults cleanly.
            done <= 1'b0;
            if (ir_envelope) begin
                if (car_cnt == CAR_LAST) begin
                    car_cnt <= '0;
                    ir_out  <= ~ir_out;
                end else begin
                    car_cnt <= car_cnt + 1'b1;
                end
            end

            if (state == IDLE) begin
                if (tx_start || tx_repeat) begin
                    state       <= LEAD_MARK;
                    cyc_cnt     <= '0;
                    units_left  <= 8'd15;
                    bit_idx     <= '0;
                    shift_word  <= {~command, command, ~address, address};
                    is_repeat   <= !tx_start;
                    busy        <= 1'b1;
                    ir_envelope <= 1'b1;
                    ir_out      <= 1'b1;
                    car_cnt     <= '0;
                end
            end else if (cyc_cnt == CYC_LAST) begin
                cyc_cnt <= '0;
                if (units_left != 8'd0) begin
                    units_left <= units_left - 8'd1;
                end else begin
                    unique case (state)
                        LEAD_MARK: begin
                            state       <= LEAD_SPACE;
                            units_left  <= is_repeat ? 8'd3 : 8'd7;
                            ir_envelope <= 1'b0;
                            ir_out      <= 1'b0;
                        end
                        LEAD_SPACE: begin
                            state       <= is_repeat ? STOP_MARK : BIT_MARK;
                            units_left  <= 8'd0;
                            ir_envelope <= 1'b1;
                            ir_out      <= 1'b1;
                            car_cnt     <= '0;
                        end
                        BIT_MARK: begin
                            state       <= BIT_SPACE;
                            units_left  <= shift_word[0] ? 8'd2 : 8'd0;
                            ir_envelope <= 1'b0;
                            ir_out      <= 1'b0;
                        end
                        BIT_SPACE: begin
                            state       <= (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
                            units_left  <= 8'd0;
                            bit_idx     <= bit_idx + 5'd1;
                            shift_word  <= shift_word >> 1;
                            ir_envelope <= 1'b1;
                            ir_out      <= 1'b1;
                            car_cnt     <= '0;
                        end
                        STOP_MARK: begin
                            state       <= GAP;
                            units_left  <= GAP_LAST;
                            ir_envelope <= 1'b0;
                            ir_out      <= 1'b0;
                        end
                        GAP: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                        default: begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            ir_envelope <= 1'b0;
                            ir_out      <= 1'b0;
                        end
                    endcase
                end
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

endmodule
